// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 256;
  localparam int unsigned TIMEOUT_DEF = 1023;

  // Requester identities: dcache on port 0, icache on port 1.
  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Width of a counter that must hold 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way picker: round-robin on ties when rr_en, else port 0.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Single requester always wins; a tie goes to the port not served last.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_D;
    if (req == 2'b11) begin
      gnt_id = rr_en ? ~last : PORT_D;
    end else if (req[1]) begin
      gnt_id = PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide data memory between dcache (port 0) and icache (port 1).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  output logic [DATA_W-1:0] r0_data_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_data_i,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic                owner_q;
  logic                last_q;
  logic                cmd_write_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  logic                gnt_valid;
  logic                gnt_id;
  logic                load;
  logic                done;
  logic                abort;
  logic                busy;
  logic                timeout_hit;

  arb_rr2 u_pick (
    .req       ({r1_enable_i, r0_enable_i}),
    .last      (last_q),
    .rr_en     (RR_EN),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign busy = (state_q == ST_BUSY);

  // This BUSY cycle is the last one allowed without an ack.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // State register; reset aborts any transaction immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant from IDLE, leave BUSY on ack (ack beats timeout).
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          load    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Winner's command is frozen for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q     <= PORT_D;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else if (load) begin
      owner_q     <= gnt_id;
      cmd_write_q <= (gnt_id == PORT_I) ? r1_write_i : r0_write_i;
      cmd_addr_q  <= (gnt_id == PORT_I) ? r1_addr_i  : r0_addr_i;
      cmd_data_q  <= (gnt_id == PORT_I) ? r1_data_i  : r0_data_i;
    end
  end

  // Watchdog counter: BUSY cycles without ack, saturating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (busy && !mem_ack_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Round-robin history and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= PORT_I;
      err_q  <= 1'b0;
    end else begin
      if (done || abort) begin
        last_q <= owner_q;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_enable_o = busy;
  assign mem_write_o  = cmd_write_q;
  assign mem_addr_o   = cmd_addr_q;
  assign mem_data_o   = cmd_data_q;
  assign err_o        = err_q;

  // Ack goes only to the owner; read data is broadcast.
  assign r0_ack_o  = busy && mem_ack_i && (owner_q == PORT_D);
  assign r1_ack_o  = busy && mem_ack_i && (owner_q == PORT_I);
  assign r0_data_o = mem_data_i;
  assign r1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: instance 0 round-robin, instance 1 fixed priority, both TIMEOUT_CYC=8.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic clk;
  logic rst_i;

  logic         en     [2][2];
  logic         wr     [2][2];
  logic [31:0]  addr   [2][2];
  logic [255:0] wdata  [2][2];
  logic         ack_o  [2][2];
  logic [255:0] rdata_o[2][2];

  logic         m_en   [2];
  logic         m_wr   [2];
  logic [31:0]  m_addr [2];
  logic [255:0] m_wdata[2];
  logic [255:0] m_rdata[2];
  logic         m_ack  [2];
  logic         err    [2];

  int checks   = 0;
  int failures = 0;

  // Behavioural model: one in-flight transaction record per instance.
  bit           mact  [2];
  bit           mown  [2];
  bit           mlast [2];
  bit           mcwr  [2];
  logic [31:0]  mcaddr[2];
  logic [255:0] mcdata[2];
  int           mwait [2];
  bit           merr  [2];

  // Observed ack order and requester-side ack memory.
  int dlog [2][64];
  int dcnt [2];
  bit seen_ack [2][2];

  // Stimulus controls.
  int mode;       // 0 random, 1 drop after ack, 2 re-request after ack, 3 manual
  int fix_delay;  // -1 random memory latency
  int mdel [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (256),
        .RR_EN       (g == 0),
        .TIMEOUT_CYC (TO)
      ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .r0_enable_i  (en[g][0]),
        .r0_write_i   (wr[g][0]),
        .r0_addr_i    (addr[g][0]),
        .r0_data_i    (wdata[g][0]),
        .r0_ack_o     (ack_o[g][0]),
        .r0_data_o    (rdata_o[g][0]),
        .r1_enable_i  (en[g][1]),
        .r1_write_i   (wr[g][1]),
        .r1_addr_i    (addr[g][1]),
        .r1_data_i    (wdata[g][1]),
        .r1_ack_o     (ack_o[g][1]),
        .r1_data_o    (rdata_o[g][1]),
        .mem_enable_o (m_en[g]),
        .mem_write_o  (m_wr[g]),
        .mem_addr_o   (m_addr[g]),
        .mem_data_o   (m_wdata[g]),
        .mem_data_i   (m_rdata[g]),
        .mem_ack_i    (m_ack[g]),
        .err_o        (err[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int inst, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h exp=%0h", nm, inst, act, exp);
    end
  endtask

  // Model update from the inputs seen at each edge.
  always @(posedge clk or negedge rst_i) begin
    for (int i = 0; i < 2; i++) begin
      bit w;
      if (!rst_i) begin
        mact[i]   <= 1'b0;
        mown[i]   <= 1'b0;
        mlast[i]  <= 1'b1;
        mcwr[i]   <= 1'b0;
        mcaddr[i] <= '0;
        mcdata[i] <= '0;
        mwait[i]  <= 0;
        merr[i]   <= 1'b0;
      end else if (!mact[i]) begin
        if (en[i][0] || en[i][1]) begin
          if (en[i][0] && en[i][1]) w = (i == 0) ? !mlast[i] : 1'b0;
          else                      w = en[i][1];
          mact[i]   <= 1'b1;
          mown[i]   <= w;
          mcwr[i]   <= wr[i][w];
          mcaddr[i] <= addr[i][w];
          mcdata[i] <= wdata[i][w];
          mwait[i]  <= 0;
        end
      end else if (m_ack[i]) begin
        mact[i]  <= 1'b0;
        mlast[i] <= mown[i];
      end else if (mwait[i] + 1 == TO) begin
        mact[i]  <= 1'b0;
        mlast[i] <= mown[i];
        merr[i]  <= 1'b1;
      end else begin
        mwait[i] <= mwait[i] + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        chk("mem_enable", i, 256'(m_en[i]), 256'(mact[i]));
        if (mact[i]) begin
          chk("mem_write", i, 256'(m_wr[i]), 256'(mcwr[i]));
          chk("mem_addr", i, 256'(m_addr[i]), 256'(mcaddr[i]));
          chk("mem_wdata", i, m_wdata[i], mcdata[i]);
        end
        for (int p = 0; p < 2; p++) begin
          bit exp_ack;
          exp_ack = mact[i] && m_ack[i] && (int'(mown[i]) == p);
          chk(p == 0 ? "r0_ack" : "r1_ack", i, 256'(ack_o[i][p]), 256'(exp_ack));
          if (exp_ack) chk(p == 0 ? "r0_rdata" : "r1_rdata", i, rdata_o[i][p], m_rdata[i]);
          seen_ack[i][p] = ack_o[i][p];
          if (ack_o[i][p] && dcnt[i] < 64) begin
            dlog[i][dcnt[i]] = p;
            dcnt[i]++;
          end
        end
        chk("err", i, 256'(err[i]), 256'(merr[i]));
      end
    end
  end

  task automatic new_cmd(input int i, input int p);
    wr[i][p]    = 1'($urandom % 2);
    addr[i][p]  = $urandom & 32'hFFFF_FFE0;
    wdata[i][p] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // One cycle of requester and memory behaviour, driven just after the edge.
  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit s;
        s = seen_ack[i][p];
        seen_ack[i][p] = 1'b0;
        case (mode)
          0: begin
            if (en[i][p]) begin
              if (s) begin
                if ($urandom % 2 == 0) en[i][p] = 1'b0;
                else new_cmd(i, p);
              end else if ($urandom % 8 == 0) begin
                new_cmd(i, p);
              end
            end else if ($urandom % 3 == 0) begin
              en[i][p] = 1'b1;
              new_cmd(i, p);
            end
          end
          1: if (en[i][p] && s) en[i][p] = 1'b0;
          2: if (en[i][p] && s) new_cmd(i, p);
          default: ;
        endcase
      end
      m_rdata[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (!m_en[i]) begin
        mdel[i]  = -1;
        m_ack[i] = (mode == 0) ? ($urandom % 10 == 0) : 1'b0;
      end else begin
        if (mdel[i] < 0)
          mdel[i] = (fix_delay >= 0) ? fix_delay :
                    (($urandom % 6 == 0) ? 1000 : int'($urandom_range(0, 9)));
        if (mdel[i] == 0) begin
          m_ack[i] = 1'b1;
        end else begin
          m_ack[i] = 1'b0;
          mdel[i]--;
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_enable", i, 256'(m_en[i]), 256'(0));
      chk("rst_r0_ack", i, 256'(ack_o[i][0]), 256'(0));
      chk("rst_r1_ack", i, 256'(ack_o[i][1]), 256'(0));
      chk("rst_err", i, 256'(err[i]), 256'(0));
      chk("rst_mem_addr", i, 256'(m_addr[i]), 256'(0));
    end
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      dcnt[i] = 0;
      mdel[i] = -1;
      seen_ack[i][0] = 1'b0;
      seen_ack[i][1] = 1'b0;
    end
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    mode = 3;
    fix_delay = -1;
    for (int i = 0; i < 2; i++) begin
      m_ack[i] = 1'b0;
      m_rdata[i] = '0;
      mdel[i] = -1;
      dcnt[i] = 0;
      for (int p = 0; p < 2; p++) begin
        en[i][p] = 1'b0;
        wr[i][p] = 1'b0;
        addr[i][p] = '0;
        wdata[i][p] = '0;
        seen_ack[i][p] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("init_mem_enable", i, 256'(m_en[i]), 256'(0));
      chk("init_mem_write", i, 256'(m_wr[i]), 256'(0));
      chk("init_mem_wdata", i, m_wdata[i], 256'(0));
      chk("init_err", i, 256'(err[i]), 256'(0));
    end
    #1;
    rst_i = 1'b1;

    // Both ports hold requests continuously; memory acks on the 2nd BUSY cycle.
    mode = 2;
    fix_delay = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      en[i][0] = 1'b1;
      en[i][1] = 1'b1;
      new_cmd(i, 0);
      new_cmd(i, 1);
    end
    steps(30);
    for (int i = 0; i < 2; i++) begin
      chk("tie_count_ge4", i, 256'(dcnt[i] >= 4), 256'(1));
      for (int k = 0; k < 4; k++)
        chk("tie_order", i, 256'(dlog[i][k]), 256'((i == 0) ? (k % 2) : 0));
    end
    // Port 0 withdraws: port 1 must now be served on both instances.
    for (int i = 0; i < 2; i++) en[i][0] = 1'b0;
    steps(12);
    for (int i = 0; i < 2; i++)
      chk("port1_after_drop", i, 256'(dlog[i][dcnt[i] - 1]), 256'(1));

    // Port 1 read at 0x200 that never completes; address change mid-BUSY ignored.
    mode = 3;
    fix_delay = 1000;
    for (int i = 0; i < 2; i++) en[i][0] = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      en[i][1] = 1'b1;
      wr[i][1] = 1'b0;
      addr[i][1] = 32'h0000_0200;
    end
    steps(2);
    for (int i = 0; i < 2; i++) addr[i][1] = 32'h0000_0300;
    steps(3);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("addr_hold", i, 256'(m_addr[i]), 256'(32'h200));
      chk("err_before_timeout", i, 256'(err[i]), 256'(0));
    end
    steps(9);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("err_after_timeout", i, 256'(err[i]), 256'(1));
      chk("no_ack_on_timeout", i, 256'(dcnt[i]), 256'(0));
      en[i][1] = 1'b0;
    end
    steps(12);

    // Port 0 read at 0x400; ack arrives on the 8th BUSY cycle and beats the watchdog.
    mode = 1;
    fix_delay = 7;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      en[i][0] = 1'b1;
      wr[i][0] = 1'b0;
      addr[i][0] = 32'h0000_0400;
    end
    steps(15);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("late_ack_count", i, 256'(dcnt[i]), 256'(1));
      chk("late_ack_port", i, 256'(dlog[i][0]), 256'(0));
      chk("late_ack_err", i, 256'(err[i]), 256'(0));
    end

    // Randomized traffic with occasional asynchronous resets.
    mode = 0;
    fix_delay = -1;
    for (int r = 0; r < 6; r++) begin
      steps(400 + int'($urandom_range(0, 50)));
      do_reset();
    end
    steps(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
